uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter byte interface between `NUM_REQ` requesters.
- Arbitration is round-robin at message granularity: a grant holds from the first byte to the byte flagged `last`, so messages never interleave on `uart_tx`.
- Sits between the internal message sources (loopback echo path, status reporter, debug dump) and the UART TX serializer in `top`.
- Optionally inserts a fixed idle gap after each message.

---
 rtl/uart_tx_arbiter.sv | 115 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART TX byte stream between NUM_REQ sources.
// Round-robin at message granularity, optional idle gap after each message.
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 0,
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        tx_valid,
    output logic [DATA_W-1:0]           tx_data,
    input  logic                        tx_ready,
    output logic [GW-1:0]               grant_id,
    output logic                        busy
);

    localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CW-1:0] GAP_LOAD =
        CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    state_t              state;
    logic [GW-1:0]       rr_ptr;
    logic [CW-1:0]       gap_cnt;
    logic                found;
    logic [GW-1:0]       winner;
    logic [GW-1:0]       cand;
    logic [GW-1:0]       next_ptr;
    logic                hs_last;
    logic [DATA_W-1:0]   req_bytes [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_bytes[i] = req_data[i*DATA_W +: DATA_W];
    end

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = GW'((int'(rr_ptr) + i) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign next_ptr = GW'((int'(grant_id) + 1) % NUM_REQ);
    assign hs_last  = (state == SEND) && req_valid[grant_id]
                   && tx_ready && req_last[grant_id];

    // Message-level grant FSM: grant holds until the accepted last byte.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            gap_cnt  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        grant_id <= winner;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (hs_last) begin
                        rr_ptr <= next_ptr;
                        if (GAP_CYCLES > 0) begin
                            state   <= GAP;
                            gap_cnt <= GAP_LOAD;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Zero-latency passthrough of the granted requester while sending.
    always_comb begin
        req_ready = '0;
        tx_valid  = 1'b0;
        tx_data   = req_bytes[grant_id];
        if (state == SEND) begin
            tx_valid            = req_valid[grant_id];
            req_ready[grant_id] = tx_ready;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: two arbiters (no gap, 8-cycle gap) driven by queued
// message sources and checked against a message-level reference model.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic        sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic        rst  [2];
    logic [3:0]  rv   [2];
    logic [31:0] rdat [2];
    logic [3:0]  rl   [2];
    logic [3:0]  rr   [2];
    logic        txr  [2];
    logic        txv  [2];
    logic [7:0]  txd  [2];
    logic [1:0]  gid  [2];
    logic        bsy  [2];

    uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .GAP_CYCLES(0)) dut0 (
        .sys_clk(sys_clk), .sys_rst(rst[0]),
        .req_valid(rv[0]), .req_data(rdat[0]), .req_last(rl[0]),
        .req_ready(rr[0]), .tx_valid(txv[0]), .tx_data(txd[0]),
        .tx_ready(txr[0]), .grant_id(gid[0]), .busy(bsy[0])
    );

    uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .GAP_CYCLES(8)) dut1 (
        .sys_clk(sys_clk), .sys_rst(rst[1]),
        .req_valid(rv[1]), .req_data(rdat[1]), .req_last(rl[1]),
        .req_ready(rr[1]), .tx_valid(txv[1]), .tx_data(txd[1]),
        .tx_ready(txr[1]), .grant_id(gid[1]), .busy(bsy[1])
    );

    logic [8:0] mem [2][4][512];
    int  wr [2][4];
    int  rp [2][4];
    int  st_at [2][4];
    int  st_len [2][4];
    bit  stalled [2][4];
    bit  rnd_mode;
    int  tx_mode [2];
    int  cyc;

    int  m_own [2];
    int  m_gap [2];
    int  m_ptr [2];
    int  m_gid [2];

    logic [7:0] lg_b [2][4096];
    int  lg_g [2][4096];
    int  lg_c [2][4096];
    int  lg_n [2];
    logic obs_txv [2];

    int n_chk = 0;
    int n_fail = 0;

    task automatic expect_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic enq_byte(int k, int i, logic [7:0] b, logic last);
        mem[k][i][wr[k][i]] = {last, b};
        wr[k][i]++;
    endtask

    task automatic enq(int k, int i, string s);
        for (int j = 0; j < s.len(); j++)
            enq_byte(k, i, s[j], (j == s.len() - 1));
    endtask

    task automatic drive();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N; i++) begin
                bit has;
                bit rs;
                has = rp[k][i] < wr[k][i];
                stalled[k][i] = has && st_len[k][i] > 0 && rp[k][i] == st_at[k][i];
                rs = rnd_mode && ($urandom_range(0, 5) == 0);
                rv[k][i] = has && !stalled[k][i] && !rs;
                rdat[k][i*8 +: 8] = has ? mem[k][i][rp[k][i]][7:0] : 8'($urandom);
                rl[k][i] = has ? mem[k][i][rp[k][i]][8] : 1'($urandom);
            end
            case (tx_mode[k])
                0: txr[k] = 1'b1;
                1: txr[k] = cyc[0];
                default: txr[k] = ($urandom_range(0, 2) != 0);
            endcase
        end
    endtask

    task automatic check_cycle();
        for (int k = 0; k < 2; k++) begin
            logic [3:0] e_rdy;
            logic e_txv;
            logic e_busy;
            e_busy = (m_own[k] >= 0) || (m_gap[k] > 0);
            e_txv = 1'b0;
            e_rdy = 4'b0;
            if (m_own[k] >= 0) begin
                e_txv = rv[k][m_own[k]];
                e_rdy[m_own[k]] = txr[k];
            end
            expect_eq($sformatf("k%0d_tx_valid", k), 32'(txv[k]), 32'(e_txv));
            expect_eq($sformatf("k%0d_req_ready", k), 32'(rr[k]), 32'(e_rdy));
            expect_eq($sformatf("k%0d_busy", k), 32'(bsy[k]), 32'(e_busy));
            expect_eq($sformatf("k%0d_grant_id", k), 32'(gid[k]), m_gid[k]);
            if (e_txv)
                expect_eq($sformatf("k%0d_tx_data", k), 32'(txd[k]),
                          32'(mem[k][m_own[k]][rp[k][m_own[k]]][7:0]));
            obs_txv[k] = txv[k];
            if (txv[k] === 1'b1 && txr[k] && lg_n[k] < 4096) begin
                lg_b[k][lg_n[k]] = txd[k];
                lg_g[k][lg_n[k]] = int'(gid[k]);
                lg_c[k][lg_n[k]] = cyc;
                lg_n[k]++;
            end
        end
    endtask

    task automatic update();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N; i++) begin
                if (rv[k][i] && rr[k][i] === 1'b1) rp[k][i]++;
                if (stalled[k][i]) st_len[k][i]--;
            end
            if (rst[k]) begin
                m_own[k] = -1;
                m_gap[k] = 0;
                m_ptr[k] = 0;
                m_gid[k] = 0;
            end else if (m_own[k] >= 0) begin
                if (rv[k][m_own[k]] && txr[k] && rl[k][m_own[k]]) begin
                    m_ptr[k] = (m_own[k] + 1) % N;
                    m_own[k] = -1;
                    m_gap[k] = (k == 1) ? 8 : 0;
                end
            end else if (m_gap[k] > 0) begin
                m_gap[k]--;
            end else begin
                for (int j = 0; j < N; j++) begin
                    int w;
                    w = (m_ptr[k] + j) % N;
                    if (m_own[k] < 0 && rv[k][w]) begin
                        m_own[k] = w;
                        m_gid[k] = w;
                    end
                end
            end
        end
    endtask

    task automatic step();
        drive();
        #4;
        check_cycle();
        update();
        @(posedge sys_clk);
        #1;
        cyc++;
    endtask

    function automatic bit all_idle();
        for (int k = 0; k < 2; k++) begin
            if (m_own[k] >= 0 || m_gap[k] > 0) return 1'b0;
            for (int i = 0; i < N; i++)
                if (rp[k][i] < wr[k][i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drain(int max);
        int n;
        n = 0;
        while (!all_idle() && n < max) begin
            step();
            n++;
        end
        expect_eq("drain_done", 32'(all_idle()), 32'd1);
    endtask

    task automatic pulse_rst(int k);
        rst[k] = 1'b1;
        step();
        rst[k] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int base2;
        int c0;
        int n;
        string hw;
        string s;

        cyc = 0;
        rnd_mode = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1;
            rv[k] = '0;
            rdat[k] = '0;
            rl[k] = '0;
            txr[k] = 1'b1;
            tx_mode[k] = 0;
            m_own[k] = -1;
            m_gap[k] = 0;
            m_ptr[k] = 0;
            m_gid[k] = 0;
            lg_n[k] = 0;
            obs_txv[k] = 1'b0;
            for (int i = 0; i < N; i++) begin
                wr[k][i] = 0;
                rp[k][i] = 0;
                st_at[k][i] = 0;
                st_len[k][i] = 0;
                stalled[k][i] = 1'b0;
            end
        end
        @(posedge sys_clk);
        #1;

        // Reset held with every requester valid; first grant goes to 0.
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < N; i++) enq(k, i, "R");
        repeat (5) step();
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        base = lg_n[0];
        base2 = lg_n[1];
        drain(200);
        expect_eq("p1_first_gid_k0", lg_g[0][base], 0);
        expect_eq("p1_first_gid_k1", lg_g[1][base2], 0);
        expect_eq("p1_count_k0", lg_n[0] - base, 4);

        // Single 3-byte message from requester 2.
        pulse_rst(0);
        base = lg_n[0];
        c0 = cyc;
        enq(0, 2, "ABC");
        drain(100);
        s = "ABC";
        expect_eq("p2_count", lg_n[0] - base, 3);
        for (int j = 0; j < 3; j++) begin
            expect_eq("p2_byte", 32'(lg_b[0][base+j]), 32'(s[j]));
            expect_eq("p2_latency", lg_c[0][base+j] - c0, j + 1);
            expect_eq("p2_gid", lg_g[0][base+j], 2);
        end
        expect_eq("p2_busy_after", 32'(bsy[0]), 0);

        // Round-robin with all requesters sending 1-byte messages.
        pulse_rst(0);
        base = lg_n[0];
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) enq_byte(0, i, 8'(8'h30 + i), 1'b1);
        drain(100);
        expect_eq("p3_count", lg_n[0] - base, 8);
        for (int j = 0; j < 8; j++) begin
            expect_eq("p3_order", 32'(lg_b[0][base+j]), 32'h30 + (j % 4));
            if (j > 0)
                expect_eq("p3_spacing", lg_c[0][base+j] - lg_c[0][base+j-1], 2);
        end

        // No interleave under toggling backpressure.
        pulse_rst(0);
        tx_mode[0] = 1;
        base = lg_n[0];
        hw = "Hello, world!";
        enq(0, 1, hw);
        enq(0, 3, "xy");
        drain(300);
        tx_mode[0] = 0;
        expect_eq("p4_count", lg_n[0] - base, 15);
        for (int j = 0; j < 13; j++) begin
            expect_eq("p4_byte", 32'(lg_b[0][base+j]), 32'(hw[j]));
            expect_eq("p4_gid", lg_g[0][base+j], 1);
        end
        expect_eq("p4_next_gid", lg_g[0][base+13], 3);
        expect_eq("p4_next_byte", 32'(lg_b[0][base+13]), 32'h78);

        // Mid-message stall and 8-cycle gap on the gapped instance.
        pulse_rst(1);
        base = lg_n[1];
        st_at[1][0] = rp[1][0] + 2;
        st_len[1][0] = 5;
        enq(1, 0, "WXYZ");
        enq(1, 1, "pq");
        drain(200);
        expect_eq("p5_count", lg_n[1] - base, 6);
        expect_eq("p5_b1_b0", lg_c[1][base+1] - lg_c[1][base], 1);
        expect_eq("p5_stall", lg_c[1][base+2] - lg_c[1][base+1], 6);
        expect_eq("p5_b3_b2", lg_c[1][base+3] - lg_c[1][base+2], 1);
        expect_eq("p5_gap", lg_c[1][base+4] - lg_c[1][base+3], 10);
        expect_eq("p5_gid_msg", lg_g[1][base+3], 0);
        expect_eq("p5_gid_next", lg_g[1][base+4], 1);

        // Reset mid-message clears the grant and the round-robin pointer.
        pulse_rst(0);
        enq(0, 2, "s");
        drain(50);
        base = lg_n[0];
        enq(0, 2, "12345");
        n = 0;
        while (lg_n[0] < base + 2 && n < 50) begin
            step();
            n++;
        end
        expect_eq("p6_two_bytes", lg_n[0] - base, 2);
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;
        rp[0][2] = wr[0][2];
        base2 = lg_n[0];
        enq(0, 1, "ab");
        enq(0, 3, "cd");
        step();
        expect_eq("p6_txv_after_rst", 32'(obs_txv[0]), 0);
        drain(100);
        expect_eq("p6_count", lg_n[0] - base2, 4);
        expect_eq("p6_first_byte", 32'(lg_b[0][base2]), 32'h61);
        expect_eq("p6_first_gid", lg_g[0][base2], 1);
        expect_eq("p6_third_gid", lg_g[0][base2+2], 3);

        // Randomized traffic, stalls, backpressure and rare resets.
        rnd_mode = 1'b1;
        tx_mode[0] = 2;
        tx_mode[1] = 2;
        for (int t = 0; t < 3000; t++) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < N; i++) begin
                    if (wr[k][i] < 480 && wr[k][i] - rp[k][i] < 4
                        && $urandom_range(0, 9) == 0) begin
                        int len;
                        len = int'($urandom_range(1, 6));
                        for (int j = 0; j < len; j++)
                            enq_byte(k, i, 8'($urandom), (j == len - 1));
                    end
                end
                rst[k] = ($urandom_range(0, 399) == 0);
            end
            step();
        end
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        rnd_mode = 1'b0;
        drain(4000);
        expect_eq("final_busy_k0", 32'(bsy[0]), 0);
        expect_eq("final_busy_k1", 32'(bsy[1]), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
